timer_bank: RTL and testbench
=============================

# timer_bank

Parametrised multi-channel programmable timer bank; successor to the fixed three-channel counter peripheral on the MIO bus. Each channel counts down on rising edges of its own tick input (typically a `clkdiv` bit) in one-shot, periodic or PWM mode. Each channel drives a waveform output and a maskable interrupt. The CPU accesses every channel through a word-addressed register window decoded by the bus block.

## Interface
Parameters:
- `CH`, 3: number of channels, 1..8.
- `W`, 32: counter, register and data width.

Ports:
- `clk` in 1: system clock; all state is updated on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `tick` in CH: per-channel count source; treated as a level; rising edge detected internally.
- `we` in 1: register write strobe, one cycle.
- `addr` in $clog2(CH)+2: {channel index, reg[1:0]}.
- `wdata` in W: write data.
- `rdata` out W: combinational read of the addressed register.
- `ch_out` out CH: per-channel waveform.
- `irq` out CH: per-channel interrupt, equal to `pending & irq_en`.
- `irq_any` out 1: OR of `irq`.

## Operation
Registers per channel, selected by `reg`:
- 0 CTRL:
  - bit0 `en`.
  - bits2:1 `mode`: 00 one-shot, 01 periodic, 10 PWM, 11 reserved.
  - bit3 `irq_en`.
  - bit4 `pending`: reads its value; writing 1 clears it; writing 0 has no effect.
- 1 LOAD: reload value, read/write.
- 2 COUNT: current count; read-only; writes are ignored.
- 3 CMP: PWM compare value, read/write.

Write rules:
- A CTRL write that changes `en` from 0 to 1 copies LOAD into COUNT in the same cycle.
- A LOAD write does not disturb a running COUNT.
- Reads of a channel index ≥ CH return 0; writes to one are ignored.

Tick handling:
- `tick_q` is a registered copy of `tick`.
- `edge = tick & ~tick_q`.
- Only an edge with `en`=1 and a valid mode advances the channel.

Per edge, by mode:
- One-shot:
  - COUNT>0: decrement.
  - COUNT==0: set `pending` and clear `en`.
  - `ch_out` = 1 while `en`, else 0.
- Periodic:
  - COUNT>0: decrement.
  - COUNT==0: reload LOAD, set `pending`, toggle `ch_out`.
- PWM:
  - Count behaviour is the same as periodic.
  - `ch_out` = (COUNT < CMP), evaluated combinationally on the current COUNT.
- Reserved: the channel holds all state; `ch_out` holds.

Boundary conditions:
- LOAD=0:
  - Periodic/PWM expire on every edge.
  - One-shot expires on the first edge.
- PWM with CMP=0: `ch_out` is constantly 0.
- PWM with CMP > LOAD: `ch_out` is constantly 1.
- Expiry and a `pending` write-1-clear in the same cycle: `pending` ends set (set wins).
- CTRL write with `en`=1 in the same cycle as an expiry edge: the write wins; COUNT = LOAD and the edge is discarded.
- CTRL write with `en`=0 in the same cycle as an edge: the channel stops; the edge is discarded.
- All arithmetic is unsigned W-bit. Decrement stops at 0 and never wraps.

## Timing
- Reset values: every register is 0; `tick_q`=0; `ch_out`=0; `irq`=0; `irq_any`=0.
  - Because `tick_q` resets to 0, a `tick` input that is high as reset is released is taken as an edge on the first clock.
- COUNT changes at the first `clk` edge where `tick`=1 and `tick_q`=0.
  - This is one cycle after `tick` rises, given `tick` is synchronous to `clk`.
- `pending`, `irq` and `irq_any` assert at the same clock edge as the expiry.
- `rdata` is valid in the same cycle as `addr`, with zero latency.
- A write becomes visible on `rdata` the cycle after `we`.
- `rst` asserted mid-count returns all state to reset values immediately, without waiting for a clock edge.

## Configuration
- `TIMER_PWM_EN` defined:
  - PWM mode is implemented.
  - The CMP register exists per channel.
- `TIMER_PWM_EN` undefined:
  - Mode 10 behaves as reserved (hold).
  - CMP is not instantiated: it reads 0 and writes are ignored.
  - One-shot and periodic behaviour are unchanged.

## Test plan
- Reset: assert `rst` with no clock running → all outputs 0. Release, then read CTRL/LOAD/COUNT/CMP of every channel → all 0.
- One-shot on ch0: LOAD=3; CTRL=0x09 (en, irq_en, one-shot); apply 4 tick edges.
  - COUNT reads 2,1,0 after edges 1–3.
  - Edge 4 sets `pending`, `irq[0]`=1, `irq_any`=1, `en`=0, `ch_out[0]`=0.
  - Write CTRL=0x10 → `irq[0]`=0.
- Periodic on ch1: LOAD=1; CTRL=0x03; apply 6 edges → `ch_out[1]` toggles on edges 2, 4 and 6; `pending` set with `irq_en`=0, so `irq[1]` stays 0.
- PWM on ch2 (`TIMER_PWM_EN`): LOAD=7, CMP=3, mode 10 → `ch_out[2]` is high for exactly 3 of every 8 edges. With CMP=0 → constantly 0.
- Collision: write CTRL with `pending`=1 in the same cycle as an expiry edge → `pending` reads 1 afterwards.
- Out of range with CH=3: write channel 3 → no register changes; read channel 3 → `rdata`=0.

Source files
------------

// File: rtl/timer_bank.sv
// -----------------------------------------------------------------------------
// timer_bank
// Multi-channel programmable down-counting timer bank with a word-addressed
// register window. Each channel counts rising edges of its own tick input in
// one-shot, periodic or PWM mode and raises a maskable interrupt on expiry.
//
// Optional feature macro: TIMER_PWM_EN
//   defined   -> PWM mode (10) and a per-channel CMP register are implemented
//   undefined -> mode 10 behaves as reserved (hold), CMP reads 0, writes dropped
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   tick     per-channel count source (level, rising edge detected here)
//   we       one-cycle register write strobe
//   addr     {channel index, reg[1:0]}; reg 0 CTRL, 1 LOAD, 2 COUNT, 3 CMP
//   wdata    write data
//   rdata    combinational read of the addressed register
//   ch_out   per-channel waveform
//   irq      per-channel interrupt (pending & irq_en)
//   irq_any  OR of irq
// CTRL layout: bit0 en, bits2:1 mode, bit3 irq_en, bit4 pending (write 1 clears)
// -----------------------------------------------------------------------------
module timer_bank #(
    parameter int CH = 3,
    parameter int W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH-1:0]         tick,
    input  logic                  we,
    input  logic [$clog2(CH)+1:0] addr,
    input  logic [W-1:0]          wdata,
    output logic [W-1:0]          rdata,
    output logic [CH-1:0]         ch_out,
    output logic [CH-1:0]         irq,
    output logic                  irq_any
);
    localparam int AW = $clog2(CH) + 2;

    localparam logic [1:0] MODE_ONESHOT  = 2'b00;
    localparam logic [1:0] MODE_PERIODIC = 2'b01;
`ifdef TIMER_PWM_EN
    localparam logic [1:0] MODE_PWM      = 2'b10;
`endif

    logic [CH-1:0] tick_q;
    logic [CH-1:0] en_q, en_d;
    logic [CH-1:0] irq_en_q, irq_en_d;
    logic [CH-1:0] pend_q, pend_d;
    logic [CH-1:0] out_q, out_d;
    logic [1:0]    mode_q  [CH];
    logic [1:0]    mode_d  [CH];
    logic [W-1:0]  load_q  [CH];
    logic [W-1:0]  load_d  [CH];
    logic [W-1:0]  count_q [CH];
    logic [W-1:0]  count_d [CH];
`ifdef TIMER_PWM_EN
    logic [W-1:0]  cmp_q   [CH];
    logic [W-1:0]  cmp_d   [CH];
`endif

    logic [AW-1:0] ch_sel_s;
    logic [1:0]    reg_sel_s;
    logic          sel_ok_s;
    logic [CH-1:0] wr_s;
    logic [CH-1:0] adv_s;
    logic [CH-1:0] expire_s;
    logic [CH-1:0] ch_out_s;

    // Modes that let a tick edge advance the channel; anything else holds.
    function automatic logic mode_valid(input logic [1:0] m);
`ifdef TIMER_PWM_EN
        return (m != 2'b11);
`else
        return (m[1] == 1'b0);
`endif
    endfunction

    assign ch_sel_s  = addr >> 2;
    assign reg_sel_s = addr[1:0];
    assign sel_ok_s  = (ch_sel_s < AW'(CH));

    // Per-channel write select, qualified tick edge and expiry detection.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            wr_s[i]     = we & sel_ok_s & (ch_sel_s == AW'(i));
            adv_s[i]    = tick[i] & ~tick_q[i] & en_q[i] & mode_valid(mode_q[i]);
            expire_s[i] = adv_s[i] & (count_q[i] == {W{1'b0}});
        end
    end

    // Waveform: out_q remembers the last shown level so reserved mode can hold it.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            case (mode_q[i])
                MODE_ONESHOT:  ch_out_s[i] = en_q[i];
                MODE_PERIODIC: ch_out_s[i] = out_q[i];
`ifdef TIMER_PWM_EN
                MODE_PWM:      ch_out_s[i] = (count_q[i] < cmp_q[i]);
`endif
                default:       ch_out_s[i] = out_q[i];
            endcase
        end
    end

    // Next-state logic; a CTRL write discards the same-cycle edge except that
    // an expiry still sets pending (set beats write-1-clear).
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            en_d[i]     = en_q[i];
            mode_d[i]   = mode_q[i];
            irq_en_d[i] = irq_en_q[i];
            count_d[i]  = count_q[i];
            out_d[i]    = ch_out_s[i];
            if (wr_s[i] && (reg_sel_s == 2'd0)) begin
                en_d[i]     = wdata[0];
                mode_d[i]   = wdata[2:1];
                irq_en_d[i] = wdata[3];
                if (wdata[0] && (!en_q[i] || adv_s[i])) begin
                    count_d[i] = load_q[i];
                end else begin
                    count_d[i] = count_q[i];
                end
            end else if (adv_s[i]) begin
                if (count_q[i] != {W{1'b0}}) begin
                    count_d[i] = count_q[i] - W'(1);
                end else begin
                    case (mode_q[i])
                        MODE_ONESHOT: en_d[i] = 1'b0;
                        MODE_PERIODIC: begin
                            count_d[i] = load_q[i];
                            out_d[i]   = ~out_q[i];
                        end
                        default: count_d[i] = load_q[i];
                    endcase
                end
            end else begin
                count_d[i] = count_q[i];
            end
            pend_d[i] = expire_s[i] |
                        (pend_q[i] & ~(wr_s[i] & (reg_sel_s == 2'd0) & wdata[4]));
            if (wr_s[i] && (reg_sel_s == 2'd1)) begin
                load_d[i] = wdata;
            end else begin
                load_d[i] = load_q[i];
            end
`ifdef TIMER_PWM_EN
            if (wr_s[i] && (reg_sel_s == 2'd3)) begin
                cmp_d[i] = wdata;
            end else begin
                cmp_d[i] = cmp_q[i];
            end
`endif
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q   <= {CH{1'b0}};
            en_q     <= {CH{1'b0}};
            irq_en_q <= {CH{1'b0}};
            pend_q   <= {CH{1'b0}};
            out_q    <= {CH{1'b0}};
            for (int i = 0; i < CH; i++) begin
                mode_q[i]  <= 2'b00;
                load_q[i]  <= {W{1'b0}};
                count_q[i] <= {W{1'b0}};
`ifdef TIMER_PWM_EN
                cmp_q[i]   <= {W{1'b0}};
`endif
            end
        end else begin
            tick_q   <= tick;
            en_q     <= en_d;
            irq_en_q <= irq_en_d;
            pend_q   <= pend_d;
            out_q    <= out_d;
            for (int i = 0; i < CH; i++) begin
                mode_q[i]  <= mode_d[i];
                load_q[i]  <= load_d[i];
                count_q[i] <= count_d[i];
`ifdef TIMER_PWM_EN
                cmp_q[i]   <= cmp_d[i];
`endif
            end
        end
    end

    // Zero-latency register read; out-of-range channels read as 0.
    always_comb begin
        rdata = {W{1'b0}};
        for (int i = 0; i < CH; i++) begin
            if (sel_ok_s && (ch_sel_s == AW'(i))) begin
                case (reg_sel_s)
                    2'd0:    rdata = {{(W-5){1'b0}}, pend_q[i], irq_en_q[i], mode_q[i], en_q[i]};
                    2'd1:    rdata = load_q[i];
                    2'd2:    rdata = count_q[i];
`ifdef TIMER_PWM_EN
                    2'd3:    rdata = cmp_q[i];
`endif
                    default: rdata = {W{1'b0}};
                endcase
            end else begin
                rdata = rdata;
            end
        end
    end

    assign ch_out  = ch_out_s;
    assign irq     = pend_q & irq_en_q;
    assign irq_any = |irq;

endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank: directed scenarios plus randomized
// traffic, all compared against a behavioural per-channel model.
module tb_timer_bank;
    localparam int CH = 3;
    localparam int W  = 32;
    localparam int AW = $clog2(CH) + 2;
`ifdef TIMER_PWM_EN
    localparam bit PWM = 1'b1;
`else
    localparam bit PWM = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          run = 1'b0;
    logic          rst = 1'b0;
    logic [CH-1:0] tick = '0;
    logic          we = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [W-1:0]  wdata = '0;
    logic [W-1:0]  rdata;
    logic [CH-1:0] ch_out;
    logic [CH-1:0] irq;
    logic          irq_any;

    int n_checks = 0;
    int n_errors = 0;

    timer_bank #(.CH(CH), .W(W)) dut (
        .clk(clk), .rst(rst), .tick(tick), .we(we), .addr(addr),
        .wdata(wdata), .rdata(rdata), .ch_out(ch_out), .irq(irq), .irq_any(irq_any)
    );

    always #5 if (run) clk = ~clk;

    // Behavioural model state.
    bit          m_en   [CH];
    bit [1:0]    m_mode [CH];
    bit          m_ie   [CH];
    bit          m_pend [CH];
    bit          m_out  [CH];
    bit          m_tq   [CH];
    logic [W-1:0] m_load [CH];
    logic [W-1:0] m_cnt  [CH];
    logic [W-1:0] m_cmp  [CH];

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_en[c] = 0; m_mode[c] = 0; m_ie[c] = 0; m_pend[c] = 0;
            m_out[c] = 0; m_tq[c] = 0; m_load[c] = 0; m_cnt[c] = 0; m_cmp[c] = 0;
        end
    endtask

    function automatic bit m_runs(input bit [1:0] md);
        return (md == 2'd0) || (md == 2'd1) || (PWM && md == 2'd2);
    endfunction

    function automatic logic [W-1:0] exp_rd(input logic [AW-1:0] a);
        int c = int'(a) / 4;
        int r = int'(a) % 4;
        if (c >= CH) return '0;
        case (r)
            0: return W'({m_pend[c], m_ie[c], m_mode[c], m_en[c]});
            1: return m_load[c];
            2: return m_cnt[c];
            default: return PWM ? m_cmp[c] : '0;
        endcase
    endfunction

    // Apply the current inputs to the model as one clock of behaviour.
    task automatic model_update();
        int  wc = int'(addr) / 4;
        int  wr = int'(addr) % 4;
        for (int c = 0; c < CH; c++) begin
            bit hit  = we && (wc == c);
            bit edg  = tick[c] && !m_tq[c];
            bit adv  = edg && m_en[c] && m_runs(m_mode[c]);
            bit expd = adv && (m_cnt[c] == 0);
            bit old_en = m_en[c];
            if (hit && wr == 0) begin
                if (wdata[0] && (!old_en || adv)) m_cnt[c] = m_load[c];
                m_en[c] = wdata[0]; m_mode[c] = wdata[2:1]; m_ie[c] = wdata[3];
                if (wdata[4]) m_pend[c] = 0;
            end else if (adv) begin
                if (m_cnt[c] > 0) m_cnt[c] = m_cnt[c] - 1;
                else if (m_mode[c] == 0) m_en[c] = 0;
                else begin
                    m_cnt[c] = m_load[c];
                    if (m_mode[c] == 1) m_out[c] = !m_out[c];
                end
            end
            if (expd) m_pend[c] = 1;
            if (hit && wr == 1) m_load[c] = wdata;
            if (hit && wr == 3 && PWM) m_cmp[c] = wdata;
            case (m_mode[c])
                2'd0: m_out[c] = m_en[c];
                2'd2: if (PWM) m_out[c] = (m_cnt[c] < m_cmp[c]);
                default: m_out[c] = m_out[c];
            endcase
            m_tq[c] = tick[c];
        end
    endtask

    // One clock: advance model, clock the DUT, compare outputs and the read port.
    task automatic step();
        logic [CH-1:0] e_out, e_irq;
        model_update();
        @(posedge clk);
        #1;
        for (int c = 0; c < CH; c++) begin
            e_out[c] = m_out[c];
            e_irq[c] = m_pend[c] & m_ie[c];
        end
        chk("ch_out", W'(ch_out), W'(e_out));
        chk("irq", W'(irq), W'(e_irq));
        chk("irq_any", W'(irq_any), W'(|e_irq));
        chk("rdata", rdata, exp_rd(addr));
    endtask

    task automatic wr(input int a, input logic [W-1:0] d);
        we = 1'b1; addr = AW'(a); wdata = d;
        step();
        we = 1'b0;
    endtask

    task automatic pulse(input int c);
        tick[c] = 1'b1; step();
        tick[c] = 1'b0; step();
    endtask

    task automatic rd(input string tag, input int a, input logic [W-1:0] exp);
        addr = AW'(a);
        #1;
        chk(tag, rdata, exp);
    endtask

    int ones;
    logic [W-1:0] ctrl_v;

    initial begin
        model_reset();
        // Reset with no clock running.
        #2 rst = 1'b1;
        #2;
        chk("rst_ch_out", W'(ch_out), '0);
        chk("rst_irq", W'(irq), '0);
        chk("rst_irq_any", W'(irq_any), '0);
        rst = 1'b0;
        for (int a = 0; a < 4 * CH; a++) rd("rst_reg", a, '0);
        run = 1'b1;

        // One-shot on channel 0.
        wr(1, 3);
        wr(0, 32'h09);
        for (int k = 1; k <= 3; k++) begin
            pulse(0);
            rd("os_count", 2, W'(3 - k));
        end
        chk("os_out_run", W'(ch_out[0]), 1);
        pulse(0);
        chk("os_irq", W'(irq[0]), 1);
        chk("os_irq_any", W'(irq_any), 1);
        chk("os_out_done", W'(ch_out[0]), 0);
        rd("os_ctrl", 0, 32'h18);
        wr(0, 32'h10);
        chk("os_irq_clr", W'(irq[0]), 0);

        // Periodic on channel 1 with LOAD=1.
        wr(5, 1);
        wr(4, 32'h03);
        for (int k = 1; k <= 6; k++) begin
            pulse(1);
            chk("per_out", W'(ch_out[1]), W'((k % 4 == 2 || k % 4 == 3) ? 1 : 0));
        end
        chk("per_irq", W'(irq[1]), 0);
        rd("per_ctrl", 4, 32'h13);

        // PWM on channel 2 (hold when PWM is not built).
        wr(9, 7);
        wr(11, 3);
        wr(8, 32'h05);
        ones = 0;
        for (int k = 0; k < 16; k++) begin
            pulse(2);
            ones += int'(ch_out[2]);
        end
        chk("pwm_duty", W'(ones), PWM ? 6 : 0);
        rd("pwm_cmp", 11, PWM ? 3 : 0);
        rd("pwm_cnt", 10, PWM ? 7 : 7);
        wr(11, 0);
        ones = 0;
        for (int k = 0; k < 8; k++) begin
            pulse(2);
            ones += int'(ch_out[2]);
        end
        chk("pwm_cmp0", W'(ones), 0);

        // Collision: expiry edge and pending write-1-clear in the same cycle.
        wr(4, 32'h13);
        for (int k = 0; k < 4 && m_cnt[1] != 0; k++) pulse(1);
        tick[1] = 1'b1;
        wr(4, 32'h13);
        tick[1] = 1'b0;
        step();
        rd("coll_ctrl", 4, 32'h13);

        // Out-of-range channel.
        wr(13, 32'hDEAD);
        wr(12, 32'h1F);
        rd("oor_rd", 13, 0);
        rd("oor_ld0", 1, 3);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            tick = CH'($urandom);
            we = ($urandom_range(0, 7) == 0);
            addr = AW'($urandom_range(0, 15));
            case (addr[1:0])
                2'd0:    wdata = W'($urandom_range(0, 31));
                2'd1:    wdata = W'($urandom_range(0, 4));
                2'd3:    wdata = W'($urandom_range(0, 6));
                default: wdata = $urandom;
            endcase
            step();
        end
        we = 1'b0;

        // Asynchronous reset between clock edges.
        wr(5, 2);
        wr(4, 32'h0B);
        pulse(1);
        rst = 1'b1;
        addr = AW'(6);
        #1;
        chk("arst_out", W'(ch_out), '0);
        chk("arst_irq", W'(irq), '0);
        chk("arst_rd", rdata, '0);
        model_reset();
        rst = 1'b0;
        for (int n = 0; n < 8; n++) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
